// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: program counter, instruction memory and IF/ID register
module instruction_fetch #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [63:0]                   branch_target,
    input  logic                          imem_wr_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_wr_addr,
    input  logic [31:0]                   imem_wr_data,
    output logic [63:0]                   pc_out,
    output logic [63:0]                   if_id_pc,
    output logic [31:0]                   if_id_instruction,
    output logic                          if_id_valid,
    output logic                          imem_fault
);

    localparam int          AW  = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0] imem [IMEM_DEPTH];
    logic        fetch_ok;
    logic [31:0] fetch_word;

    // In range means every PC bit above the byte span of the memory is zero.
    assign fetch_ok   = (pc_out[1:0] == 2'b00) && (pc_out[63:AW+2] == '0);
    assign fetch_word = fetch_ok ? imem[pc_out[AW+1:2]] : NOP;

    // Program storage survives reset, so the write port has no reset term.
    always_ff @(posedge clk) begin
        if (imem_wr_en) begin
            imem[imem_wr_addr] <= imem_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out            <= RESET_PC;
            if_id_pc          <= 64'h0;
            if_id_instruction <= NOP;
            if_id_valid       <= 1'b0;
            imem_fault        <= 1'b0;
        end else if (flush) begin
            pc_out            <= branch_target;
            if_id_pc          <= 64'h0;
            if_id_instruction <= NOP;
            if_id_valid       <= 1'b0;
        end else if (!stall) begin
            pc_out            <= pc_out + 64'd4;
            if_id_pc          <= pc_out;
            if_id_instruction <= fetch_word;
            if_id_valid       <= 1'b1;
            if (!fetch_ok) begin
                imem_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic        imem_wr_en = 1'b0;
    logic [7:0]  imem_wr_addr = 8'h0;
    logic [31:0] imem_wr_data = 32'h0;
    logic [63:0] pc_out;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        imem_fault;

    instruction_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .branch_target     (branch_target),
        .imem_wr_en        (imem_wr_en),
        .imem_wr_addr      (imem_wr_addr),
        .imem_wr_data      (imem_wr_data),
        .pc_out            (pc_out),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .imem_fault        (imem_fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [63:0] m_pc;
    logic [63:0] m_if_pc;
    logic [31:0] m_if_ins;
    logic        m_if_valid;
    logic        m_fault;

    task automatic m_reset();
        m_pc = 64'h0; m_if_pc = 64'h0; m_if_ins = NOP; m_if_valid = 1'b0; m_fault = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model, and waits until just after the edge.
    task automatic step(input logic s, input logic f, input logic [63:0] tgt,
                        input logic we, input logic [7:0] wa, input logic [31:0] wd);
        logic        bad;
        logic [31:0] word;
        stall = s; flush = f; branch_target = tgt;
        imem_wr_en = we; imem_wr_addr = wa; imem_wr_data = wd;
        bad  = (m_pc % 4 != 0) || (m_pc >= 64'(4 * DEPTH));
        word = bad ? NOP : m_mem[m_pc / 4];
        if (f) begin
            m_pc = tgt; m_if_pc = 64'h0; m_if_ins = NOP; m_if_valid = 1'b0;
        end else if (!s) begin
            m_if_pc = m_pc; m_if_ins = word; m_if_valid = 1'b1;
            if (bad) m_fault = 1'b1;
            m_pc = m_pc + 64'd4;
        end
        if (we) m_mem[wa] = wd;
        @(posedge clk);
        #1;
        stall = 1'b0; flush = 1'b0; imem_wr_en = 1'b0;
    endtask

    task automatic norm();
        step(1'b0, 1'b0, 64'h0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic redirect(input logic [63:0] tgt);
        step(1'b0, 1'b1, tgt, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (pc_out !== 64'h0) begin errors++; $display("FAIL reset_pc actual=%h expected=0", pc_out); end
        checks++;
        if (if_id_pc !== 64'h0) begin errors++; $display("FAIL reset_if_id_pc actual=%h expected=0", if_id_pc); end
        checks++;
        if (if_id_instruction !== NOP) begin errors++; $display("FAIL reset_ins actual=%h expected=%h", if_id_instruction, NOP); end
        checks++;
        if (if_id_valid !== 1'b0 || imem_fault !== 1'b0) begin
            errors++; $display("FAIL reset_flags actual valid=%b fault=%b expected 0 0", if_id_valid, imem_fault);
        end
        m_reset();
        // Load the whole memory under reset: random filler, then the program.
        @(negedge clk);
        for (int i = 0; i < DEPTH + 4; i++) begin
            imem_wr_en   = 1'b1;
            imem_wr_addr = (i < DEPTH) ? 8'(i) : 8'(i - DEPTH);
            imem_wr_data = (i < DEPTH) ? $urandom :
                           (i == DEPTH)     ? 32'h00A00093 :
                           (i == DEPTH + 1) ? 32'h00100113 :
                           (i == DEPTH + 2) ? 32'h002081B3 : 32'h00000013;
            m_mem[imem_wr_addr] = imem_wr_data;
            @(negedge clk);
        end
        imem_wr_en = 1'b0;
        checks++;
        if (pc_out !== 64'h0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hold actual pc=%h valid=%b expected 0 0", pc_out, if_id_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequence();
        logic [31:0] prog [4];
        prog[0] = 32'h00A00093; prog[1] = 32'h00100113; prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_out !== 64'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] actual=%h expected=%h", i, pc_out, 4 * i); end
            norm();
            checks++;
            if (if_id_pc !== 64'(4 * i) || if_id_instruction !== prog[i] || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_ifid[%0d] actual=%h/%h/%b expected=%h/%h/1", i, if_id_pc, if_id_instruction, if_id_valid, 4 * i, prog[i]);
            end
        end
    endtask

    task automatic test_stall();
        redirect(64'h4);
        norm();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 64'h0, 1'b0, 8'h0, 32'h0);
            checks++;
            if (pc_out !== 64'h8 || if_id_pc !== 64'h4 || if_id_instruction !== 32'h00100113 || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d] actual=%h %h/%h/%b expected=8 4/00100113/1", i, pc_out, if_id_pc, if_id_instruction, if_id_valid);
            end
        end
        norm();
        checks++;
        if (pc_out !== 64'hc || if_id_pc !== 64'h8 || if_id_instruction !== 32'h002081B3) begin
            errors++; $display("FAIL stall_release actual=%h %h/%h expected=c 8/002081b3", pc_out, if_id_pc, if_id_instruction);
        end
    endtask

    task automatic test_flush(input logic with_stall);
        redirect(64'h4);
        norm();
        step(with_stall, 1'b1, 64'h40, 1'b0, 8'h0, 32'h0);
        checks++;
        if (pc_out !== 64'h40 || if_id_pc !== 64'h0 || if_id_instruction !== NOP || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble(stall=%b) actual=%h %h/%h/%b expected=40 0/13/0", with_stall, pc_out, if_id_pc, if_id_instruction, if_id_valid);
        end
        norm();
        checks++;
        if (if_id_pc !== 64'h40 || if_id_valid !== 1'b1 || if_id_instruction !== m_mem[16] || pc_out !== 64'h44) begin
            errors++;
            $display("FAIL flush_target(stall=%b) actual=%h/%h/%b pc=%h expected=40/%h/1 pc=44", with_stall, if_id_pc, if_id_instruction, if_id_valid, pc_out, m_mem[16]);
        end
    endtask

    task automatic test_write_fetch();
        logic [31:0] old_word;
        redirect(64'h20);
        old_word = m_mem[8];
        step(1'b0, 1'b0, 64'h0, 1'b1, 8'd8, 32'hDEADBEEF);
        checks++;
        if (if_id_instruction !== old_word) begin
            errors++; $display("FAIL write_same_edge actual=%h expected=%h", if_id_instruction, old_word);
        end
        redirect(64'h20);
        norm();
        checks++;
        if (if_id_instruction !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_visible actual=%h expected=deadbeef", if_id_instruction);
        end
    endtask

    task automatic test_async_reset();
        redirect(64'h40);
        norm();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pc_out !== 64'h0 || if_id_pc !== 64'h0 || if_id_instruction !== NOP || if_id_valid !== 1'b0 || imem_fault !== 1'b0) begin
            errors++;
            $display("FAIL async_reset actual=%h %h/%h/%b fault=%b expected=0 0/13/0 fault=0", pc_out, if_id_pc, if_id_instruction, if_id_valid, imem_fault);
        end
        m_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        norm();
        checks++;
        if (if_id_instruction !== m_mem[0] || if_id_pc !== 64'h0 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL reset_imem_kept actual=%h/%h/%b expected=0/%h/1", if_id_pc, if_id_instruction, if_id_valid, m_mem[0]);
        end
    endtask

    task automatic test_fault(input logic [63:0] tgt);
        redirect(tgt);
        norm();
        checks++;
        if (if_id_pc !== tgt || if_id_instruction !== NOP || if_id_valid !== 1'b1 || imem_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_capture(%h) actual=%h/%h/%b fault=%b expected=%h/13/1 fault=1", tgt, if_id_pc, if_id_instruction, if_id_valid, imem_fault, tgt);
        end
        redirect(64'h0);
        norm();
        norm();
        checks++;
        if (imem_fault !== 1'b1 || if_id_instruction !== m_mem[1]) begin
            errors++; $display("FAIL fault_sticky actual fault=%b ins=%h expected fault=1 ins=%h", imem_fault, if_id_instruction, m_mem[1]);
        end
        test_async_reset();
    endtask

    task automatic test_boundary();
        redirect(64'(4 * DEPTH - 4));
        norm();
        checks++;
        if (imem_fault !== 1'b0 || if_id_instruction !== m_mem[DEPTH - 1] || pc_out !== 64'(4 * DEPTH)) begin
            errors++;
            $display("FAIL last_word actual fault=%b ins=%h pc=%h expected fault=0 ins=%h pc=%h", imem_fault, if_id_instruction, pc_out, m_mem[DEPTH - 1], 4 * DEPTH);
        end
        norm();
        checks++;
        if (imem_fault !== 1'b1 || if_id_instruction !== NOP || if_id_pc !== 64'(4 * DEPTH)) begin
            errors++; $display("FAIL past_end actual fault=%b ins=%h pc=%h expected fault=1 ins=13", imem_fault, if_id_instruction, if_id_pc);
        end
    endtask

    task automatic test_random();
        logic [63:0] tgt;
        logic [1:0]  kind;
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) begin
                #1;
                rst = 1'b1;
                m_reset();
                @(posedge clk);
                #2;
                rst = 1'b0;
            end
            kind = 2'($urandom_range(0, 3));
            tgt  = (kind == 2'd0) ? {$urandom, $urandom} :
                   (kind == 2'd1) ? 64'($urandom_range(0, 4 * DEPTH + 8)) :
                                    64'($urandom_range(0, DEPTH - 1) * 4);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt,
                 $urandom_range(0, 1) == 1, 8'($urandom), $urandom);
            checks++;
            if ({pc_out, if_id_pc, if_id_instruction, if_id_valid, imem_fault} !==
                {m_pc, m_if_pc, m_if_ins, m_if_valid, m_fault}) begin
                errors++;
                $display("FAIL random[%0d] actual=%h %h/%h/%b fault=%b expected=%h %h/%h/%b fault=%b", i,
                         pc_out, if_id_pc, if_id_instruction, if_id_valid, imem_fault,
                         m_pc, m_if_pc, m_if_ins, m_if_valid, m_fault);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sequence();
        test_stall();
        test_flush(1'b0);
        test_flush(1'b1);
        test_write_fetch();
        test_fault(64'h2);
        test_fault(64'(4 * DEPTH));
        test_boundary();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the five-stage RISC-V pipeline: holds the program counter, reads a word-addressed instruction memory, and drives the IF/ID pipeline register that feeds `instruction_decode`. Supports hazard stall, branch-taken flush with redirect, and a synchronous write port used to load programs. It is the producer end of the instruction stream that decode consumes.

## Interface
Parameters:
- `IMEM_DEPTH`, 256, number of 32-bit instruction words; power of two.
- `RESET_PC`, 64'h0, PC value after reset; must be 4-byte aligned.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID register (load-use hazard).
- `flush`  in  1  branch taken; redirect PC, insert bubble.
- `branch_target`  in  64  redirect address, sampled when `flush`=1.
- `imem_wr_en`  in  1  instruction-memory write enable.
- `imem_wr_addr`  in  $clog2(IMEM_DEPTH)  word index to write.
- `imem_wr_data`  in  32  word to write.
- `pc_out`  out  64  current fetch PC.
- `if_id_pc`  out  64  PC of instruction held in IF/ID.
- `if_id_instruction`  out  32  instruction held in IF/ID.
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble.
- `imem_fault`  out  1  sticky: an out-of-range or misaligned PC was fetched.

## Operation
- Fetch word: if `pc_out[1:0]`==0 and `pc_out` < 4*IMEM_DEPTH, word = imem[`pc_out`>>2]; otherwise word = NOP 32'h00000013 and fault condition true.
- Read is combinational from `pc_out`; write is synchronous on `clk` when `imem_wr_en`=1.
- Same-edge write and fetch of the same word: IF/ID captures the old contents; new value visible from next cycle.
- imem is not cleared by `rst`; contents persist across reset.
- Per-edge priority: `rst` > `flush` > `stall` > normal.
- Normal: `pc_out` <= `pc_out`+4 (mod 2^64); IF/ID <= {`pc_out`, fetch word, valid=1}.
- Stall: `pc_out` and all IF/ID outputs hold. imem writes still occur.
- Flush (overrides stall): `pc_out` <= `branch_target`; IF/ID <= bubble {pc=0, instruction=32'h00000013, valid=0}. The word at the old PC is discarded; no fault raised for it.
- Fault: `imem_fault` sets on a normal (non-stall, non-flush) capture when fault condition is true; the captured entry is {`pc_out`, NOP, valid=1}. Stays 1 until `rst`.
- Misaligned `branch_target` is accepted as-is; fault raised when that PC is captured.

## Timing
- Reset values (asynchronous, immediate on `rst` rise): `pc_out`=RESET_PC, `if_id_pc`=0, `if_id_instruction`=32'h00000013, `if_id_valid`=0, `imem_fault`=0.
- First edge after `rst` falls: IF/ID captures word at RESET_PC, `pc_out` becomes RESET_PC+4.
- Fetch latency: 1 cycle from `pc_out`=X to `if_id_pc`=X.
- Flush: redirect visible on `pc_out` after 1 edge; target instruction in IF/ID after 2 edges; exactly one bubble.
- `stall` held N cycles freezes outputs for exactly N edges.
- Reset asserted mid-operation aborts everything; no partial update on that edge.

## Test plan
- Load imem[0..3]=0x00A00093, 0x00100113, 0x002081B3, 0x00000013 under reset, release -> `pc_out` 0,4,8,12 on successive edges; `if_id_pc`/`if_id_instruction` follow one cycle later, `if_id_valid`=1.
- Stall 2 cycles while `pc_out`=8 -> `pc_out` stays 8, IF/ID holds {4, 0x00100113, 1}; resumes with {8, 0x002081B3} on release.
- `flush`=1, `branch_target`=0x40 at `pc_out`=8 -> next edge `pc_out`=0x40, IF/ID={0, 0x13, 0}; following edge `if_id_pc`=0x40, valid=1.
- `flush`=1 and `stall`=1 together -> flush behaviour exactly as above.
- `branch_target`=0x2 -> two edges later IF/ID={0x2, 0x13, 1}, `imem_fault`=1; fault stays 1 through later valid fetches; clears only on `rst`. Repeat with target 4*IMEM_DEPTH.
- Assert `rst` between edges while running at `pc_out`=0x40 -> all outputs at reset values before next edge; imem contents intact on restart.
